// File: rtl/sb_i2c_sysbus_ctrl.sv
// System-bus master: programs the hard I2C block at start-up, then forwards single register commands.
// Define SB_I2C_CTRL_TIMEOUT_EN to add an ack-wait timeout (TIMEOUT_CYCLES clocks).
module sb_i2c_sysbus_ctrl #(
    parameter logic [3:0] BUS_ADDR74     = 4'b0001,
    parameter logic [9:0] PRESCALE       = 10'd30,
    parameter logic [7:0] CR1_INIT       = 8'h80,
    parameter logic [7:0] TIMEOUT_CYCLES = 8'd255
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       cmd_valid_i,
    output logic       cmd_ready_o,
    input  logic       cmd_write_i,
    input  logic [3:0] cmd_addr_i,
    input  logic [7:0] cmd_data_i,
    output logic       rsp_valid_o,
    output logic [7:0] rsp_data_o,
    output logic       rsp_timeout_o,
    output logic       init_done_o,
    output logic       sb_stb_o,
    output logic       sb_rw_o,
    output logic [7:0] sb_adr_o,
    output logic [7:0] sb_dat_o,
    input  logic [7:0] sb_dat_i,
    input  logic       sb_ack_i
);

    localparam int unsigned DW    = 8;
    localparam int unsigned CNT_W = 8;

    typedef enum logic [2:0] {
        S_INIT_CR1, S_INIT_BRLSB, S_INIT_BRMSB, S_IDLE, S_XFER, S_GAP
    } state_t;

    // Which write is in flight, so GAP knows where to go and XFER knows whether to respond.
    typedef enum logic [1:0] {
        STEP_CR1, STEP_BRLSB, STEP_BRMSB, STEP_USER
    } step_t;

    state_t        r_state, w_state_nxt;
    step_t         r_step,  w_step_nxt;
    logic          r_stb,   w_stb_nxt;
    logic          r_rw,    w_rw_nxt;
    logic [DW-1:0] r_adr,   w_adr_nxt;
    logic [DW-1:0] r_dat,   w_dat_nxt;
    logic          r_ready, w_ready_nxt;
    logic          r_done,  w_done_nxt;
    logic          r_rsp_valid, w_rsp_valid_nxt;
    logic [DW-1:0] r_rsp_data,  w_rsp_data_nxt;

`ifdef SB_I2C_CTRL_TIMEOUT_EN
    logic             r_rsp_timeout, w_rsp_timeout_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
    assign w_cnt_inc     = CNT_W'(r_cnt + CNT_W'(1));
    assign rsp_timeout_o = r_rsp_timeout;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = ^{TIMEOUT_CYCLES, CNT_W'(0)};
    assign rsp_timeout_o    = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= S_INIT_CR1;
            r_step      <= STEP_CR1;
            r_stb       <= 1'b0;
            r_rw        <= 1'b0;
            r_adr       <= '0;
            r_dat       <= '0;
            r_ready     <= 1'b0;
            r_done      <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
`ifdef SB_I2C_CTRL_TIMEOUT_EN
            r_rsp_timeout <= 1'b0;
            r_cnt         <= '0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_step      <= w_step_nxt;
            r_stb       <= w_stb_nxt;
            r_rw        <= w_rw_nxt;
            r_adr       <= w_adr_nxt;
            r_dat       <= w_dat_nxt;
            r_ready     <= w_ready_nxt;
            r_done      <= w_done_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_data  <= w_rsp_data_nxt;
`ifdef SB_I2C_CTRL_TIMEOUT_EN
            r_rsp_timeout <= w_rsp_timeout_nxt;
            r_cnt         <= w_cnt_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_step_nxt      = r_step;
        w_stb_nxt       = r_stb;
        w_rw_nxt        = r_rw;
        w_adr_nxt       = r_adr;
        w_dat_nxt       = r_dat;
        w_done_nxt      = r_done;
        w_rsp_valid_nxt = 1'b0;
        w_rsp_data_nxt  = r_rsp_data;
`ifdef SB_I2C_CTRL_TIMEOUT_EN
        w_rsp_timeout_nxt = 1'b0;
        w_cnt_nxt         = r_cnt;
`endif
        case (r_state)
            S_INIT_CR1: begin
                w_adr_nxt   = {BUS_ADDR74, 4'h8};
                w_dat_nxt   = CR1_INIT;
                w_rw_nxt    = 1'b1;
                w_stb_nxt   = 1'b1;
                w_step_nxt  = STEP_CR1;
                w_state_nxt = S_XFER;
            end
            S_INIT_BRLSB: begin
                w_adr_nxt   = {BUS_ADDR74, 4'hA};
                w_dat_nxt   = PRESCALE[7:0];
                w_rw_nxt    = 1'b1;
                w_stb_nxt   = 1'b1;
                w_step_nxt  = STEP_BRLSB;
                w_state_nxt = S_XFER;
            end
            S_INIT_BRMSB: begin
                w_adr_nxt   = {BUS_ADDR74, 4'hB};
                w_dat_nxt   = {6'b0, PRESCALE[9:8]};
                w_rw_nxt    = 1'b1;
                w_stb_nxt   = 1'b1;
                w_step_nxt  = STEP_BRMSB;
                w_state_nxt = S_XFER;
            end
            S_IDLE: begin
                if (cmd_valid_i && r_ready) begin
                    w_adr_nxt   = {BUS_ADDR74, cmd_addr_i};
                    w_dat_nxt   = cmd_data_i;
                    w_rw_nxt    = cmd_write_i;
                    w_stb_nxt   = 1'b1;
                    w_step_nxt  = STEP_USER;
                    w_state_nxt = S_XFER;
                end
            end
            S_XFER: begin
                // Ack has priority over a timeout landing on the same cycle.
                if (sb_ack_i) begin
                    w_stb_nxt   = 1'b0;
                    w_state_nxt = S_GAP;
                    case (r_step)
                        STEP_USER: begin
                            w_rsp_valid_nxt = 1'b1;
                            w_rsp_data_nxt  = r_rw ? DW'(0) : sb_dat_i;
                        end
                        STEP_BRMSB: begin
                            w_step_nxt = STEP_USER;
                            w_done_nxt = 1'b1;
                        end
                        STEP_BRLSB: w_step_nxt = STEP_BRMSB;
                        default:    w_step_nxt = STEP_BRLSB;
                    endcase
                end
`ifdef SB_I2C_CTRL_TIMEOUT_EN
                else if (w_cnt_inc == TIMEOUT_CYCLES) begin
                    w_stb_nxt   = 1'b0;
                    w_state_nxt = S_GAP;
                    if (r_step == STEP_USER) begin
                        w_rsp_valid_nxt   = 1'b1;
                        w_rsp_timeout_nxt = 1'b1;
                        w_rsp_data_nxt    = '0;
                    end else begin
                        w_step_nxt = STEP_CR1;
                    end
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
`endif
            end
            S_GAP: begin
                case (r_step)
                    STEP_CR1:   w_state_nxt = S_INIT_CR1;
                    STEP_BRLSB: w_state_nxt = S_INIT_BRLSB;
                    STEP_BRMSB: w_state_nxt = S_INIT_BRMSB;
                    default:    w_state_nxt = S_IDLE;
                endcase
            end
            default: w_state_nxt = S_INIT_CR1;
        endcase
`ifdef SB_I2C_CTRL_TIMEOUT_EN
        if (r_state != S_XFER) w_cnt_nxt = '0;
`endif
        w_ready_nxt = (w_state_nxt == S_IDLE) && w_done_nxt;
    end

    assign sb_stb_o    = r_stb;
    assign sb_rw_o     = r_rw;
    assign sb_adr_o    = r_adr;
    assign sb_dat_o    = r_dat;
    assign cmd_ready_o = r_ready;
    assign init_done_o = r_done;
    assign rsp_valid_o = r_rsp_valid;
    assign rsp_data_o  = r_rsp_data;

endmodule

// File: tb/tb_sb_i2c_sysbus_ctrl.sv
// Bench for sb_i2c_sysbus_ctrl: vector table, directed corner sequences and random commands
// checked against a transaction-level model with a behavioural bus slave.
module tb_sb_i2c_sysbus_ctrl;

    localparam logic [7:0] TMO = 8'd10;
`ifdef SB_I2C_CTRL_TIMEOUT_EN
    localparam int HOLD = 5;
`else
    localparam int HOLD = 40;
`endif

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       cmd_valid_i, cmd_ready_o, cmd_write_i;
    logic [3:0] cmd_addr_i;
    logic [7:0] cmd_data_i;
    logic       rsp_valid_o, rsp_timeout_o, init_done_o;
    logic [7:0] rsp_data_o;
    logic       sb_stb_o, sb_rw_o, sb_ack_i;
    logic [7:0] sb_adr_o, sb_dat_o, sb_dat_i;

    sb_i2c_sysbus_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_write_i(cmd_write_i), .cmd_addr_i(cmd_addr_i), .cmd_data_i(cmd_data_i),
        .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o), .rsp_timeout_o(rsp_timeout_o),
        .init_done_o(init_done_o),
        .sb_stb_o(sb_stb_o), .sb_rw_o(sb_rw_o), .sb_adr_o(sb_adr_o), .sb_dat_o(sb_dat_o),
        .sb_dat_i(sb_dat_i), .sb_ack_i(sb_ack_i)
    );

    typedef struct {
        logic       wr;
        logic [3:0] addr;
        logic [7:0] data;
        int         wt;
        logic [7:0] rdata;
        logic [7:0] exp_adr;
        logic [7:0] exp_dat;
        logic [7:0] exp_rsp;
    } vec_t;

    typedef struct {
        logic [7:0] adr;
        logic [7:0] dat;
        logic       rw;
    } txn_t;

    txn_t       obs_q[$];
    int         total = 0, bad = 0, cyc = 0, rsp_cnt = 0, last_ack_cyc = 0;
    int         slave_wait = 1, scnt = 0;
    logic [7:0] slave_rdata = 8'h00;
    bit         spur_en = 1'b0;
    logic [16:0] sref;

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;
    always @(negedge clk_i) if (rsp_valid_o === 1'b1) rsp_cnt++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Bus slave: acks in the (slave_wait+1)-th strobe cycle, logs acked transfers, checks hold.
    always @(negedge clk_i) begin
        txn_t t;
        if (sb_stb_o === 1'b1) begin
            if (scnt == 0) sref = {sb_adr_o, sb_dat_o, sb_rw_o};
            else chk("bus_hold", {sb_adr_o, sb_dat_o, sb_rw_o}, sref);
            if (scnt == slave_wait) begin
                sb_ack_i = 1'b1;
                sb_dat_i = slave_rdata;
                t.adr = sb_adr_o; t.dat = sb_dat_o; t.rw = sb_rw_o;
                obs_q.push_back(t);
                last_ack_cyc = cyc;
            end else begin
                sb_ack_i = 1'b0;
                sb_dat_i = 8'($urandom);
            end
            scnt++;
        end else begin
            scnt     = 0;
            sb_ack_i = spur_en ? 1'($urandom_range(0, 1)) : 1'b0;
            sb_dat_i = 8'($urandom);
        end
    end

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_ready;
        int n = 0;
        while (cmd_ready_o !== 1'b1 && n < 200) begin tick; n++; end
        chk("ready_wait", cmd_ready_o, 1);
    endtask

    task automatic check_txn(input string tag, input int idx, input logic [7:0] ea,
                             input logic [7:0] ed, input logic erw);
        txn_t t;
        t.adr = 8'hxx; t.dat = 8'hxx; t.rw = 1'bx;
        if (obs_q.size() > idx) t = obs_q[idx];
        chk($sformatf("%s_txn%0d", tag, idx), {t.adr, t.dat, t.rw}, {ea, ed, erw});
    endtask

    task automatic do_cmd(input string tag, input logic wr, input logic [3:0] a, input logic [7:0] d,
                          input int wt, input logic [7:0] rd, input logic [7:0] ea,
                          input logic [7:0] ed, input logic [7:0] er);
        int acc, n, r0;
        r0 = rsp_cnt;
        obs_q.delete();
        slave_wait = wt; slave_rdata = rd;
        cmd_valid_i = 1'b1; cmd_write_i = wr; cmd_addr_i = a; cmd_data_i = d;
        wait_ready;
        tick;
        acc = cyc;
        cmd_valid_i = 1'b0; cmd_write_i = 1'($urandom); cmd_addr_i = 4'($urandom); cmd_data_i = 8'($urandom);
        chk({tag, "_stb_first"}, {sb_stb_o, sb_adr_o, sb_dat_o, sb_rw_o}, {1'b1, ea, ed, wr});
        n = 0;
        while (rsp_valid_o !== 1'b1 && n < wt + 20) begin tick; n++; end
        chk({tag, "_rsp_valid"}, rsp_valid_o, 1);
        chk({tag, "_latency"}, cyc - acc + 1, wt + 2);
        chk({tag, "_rsp_data"}, rsp_data_o, er);
        chk({tag, "_rsp_timeout"}, rsp_timeout_o, 0);
        chk({tag, "_gap"}, {sb_stb_o, cmd_ready_o}, 2'b00);
        tick;
        chk({tag, "_rsp_pulse"}, rsp_valid_o, 0);
        chk({tag, "_idle_ready"}, {cmd_ready_o, init_done_o}, 2'b11);
        chk({tag, "_rsp_count"}, rsp_cnt, r0 + 1);
        chk({tag, "_txn_count"}, obs_q.size(), 1);
        check_txn(tag, 0, ea, ed, wr);
    endtask

    // Asserts reset between clock edges and checks the outputs clear with no edge in between.
    task automatic apply_reset(input string tag);
        #2 rst_ni = 1'b0;
        #1;
        chk({tag, "_async"}, {sb_stb_o, sb_rw_o, cmd_ready_o, rsp_valid_o, rsp_timeout_o, init_done_o,
                             sb_adr_o, sb_dat_o, rsp_data_o}, 0);
        repeat (3) tick;
        chk({tag, "_hold"}, {sb_stb_o, cmd_ready_o, init_done_o, rsp_data_o}, 0);
    endtask

    task automatic check_init(input string tag);
        int n = 0, r0;
        r0 = rsp_cnt;
        while (init_done_o !== 1'b1 && n < 300) begin tick; n++; end
        chk({tag, "_done"}, init_done_o, 1);
        chk({tag, "_done_after_ack"}, cyc, last_ack_cyc + 1);
        chk({tag, "_gap"}, {sb_stb_o, cmd_ready_o}, 2'b00);
        chk({tag, "_writes"}, obs_q.size(), 3);
        check_txn(tag, 0, 8'h18, 8'h80, 1'b1);
        check_txn(tag, 1, 8'h1A, 8'h1E, 1'b1);
        check_txn(tag, 2, 8'h1B, 8'h00, 1'b1);
        tick;
        chk({tag, "_ready"}, {cmd_ready_o, init_done_o}, 2'b11);
        chk({tag, "_no_rsp"}, rsp_cnt, r0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        vec_t       vecs[6];
        logic       wr;
        logic [3:0] a;
        logic [7:0] d, rd;
        int         wt, n, hi, lo, acc, r0;
        bit         rose, rdy_gap, rdy_last;

        vecs[0] = '{1'b1, 4'hD, 8'hA5, 3, 8'h00, 8'h1D, 8'hA5, 8'h00};
        vecs[1] = '{1'b0, 4'hC, 8'h77, 2, 8'h3C, 8'h1C, 8'h77, 8'h3C};
        vecs[2] = '{1'b1, 4'h0, 8'hFF, 0, 8'h55, 8'h10, 8'hFF, 8'h00};
        vecs[3] = '{1'b0, 4'hF, 8'h00, 0, 8'hC3, 8'h1F, 8'h00, 8'hC3};
        vecs[4] = '{1'b0, 4'h8, 8'h12, 5, 8'h81, 8'h18, 8'h12, 8'h81};
        vecs[5] = '{1'b0, 4'h4, 8'h00, 9, 8'h5A, 8'h14, 8'h00, 8'h5A};

        rst_ni = 1'b1; cmd_valid_i = 1'b0; cmd_write_i = 1'b0; cmd_addr_i = 4'h0; cmd_data_i = 8'h00;
        sb_ack_i = 1'b0; sb_dat_i = 8'h00;
        tick;

        // Power-up reset and init sequence.
        apply_reset("rst0");
        obs_q.delete(); slave_wait = 1;
        rst_ni = 1'b1;
        check_init("init");

        foreach (vecs[i])
            do_cmd($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].wt,
                   vecs[i].rdata, vecs[i].exp_adr, vecs[i].exp_dat, vecs[i].exp_rsp);

        // Back-to-back: valid stays high; the second command's fields sit on the inputs during the first XFER.
        r0 = rsp_cnt; obs_q.delete();
        slave_wait = 1; slave_rdata = 8'h44;
        cmd_valid_i = 1'b1; cmd_write_i = 1'b1; cmd_addr_i = 4'h2; cmd_data_i = 8'h11;
        wait_ready;
        tick;
        cmd_write_i = 1'b0; cmd_addr_i = 4'h3; cmd_data_i = 8'h22;
        lo = 0; rose = 1'b0; rdy_gap = 1'b1; rdy_last = 1'b0;
        for (int i = 0; i < 30 && !rose; i++) begin
            tick;
            if (sb_stb_o !== 1'b1) begin
                lo++;
                if (lo == 1) rdy_gap = cmd_ready_o;
                rdy_last = cmd_ready_o;
            end else if (lo > 0) begin
                rose = 1'b1;
            end
        end
        cmd_valid_i = 1'b0;
        chk("b2b_second_strobe", rose, 1);
        // One GAP cycle, then the IDLE cycle in which ready is high and the accept happens.
        chk("b2b_strobe_low_cycles", lo, 2);
        chk("b2b_ready_in_gap", rdy_gap, 0);
        chk("b2b_ready_before_accept", rdy_last, 1);
        n = 0;
        while (rsp_valid_o !== 1'b1 && n < 20) begin tick; n++; end
        chk("b2b_rsp_data", {rsp_valid_o, rsp_data_o}, {1'b1, 8'h44});
        tick; tick;
        chk("b2b_rsp_count", rsp_cnt, r0 + 2);
        chk("b2b_txn_count", obs_q.size(), 2);
        check_txn("b2b", 0, 8'h12, 8'h11, 1'b1);
        check_txn("b2b", 1, 8'h13, 8'h22, 1'b0);

        // Random commands with spurious acks while the strobe is low.
        spur_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            wr = 1'($urandom); a = 4'($urandom); d = 8'($urandom); rd = 8'($urandom);
            wt = $urandom_range(0, 6);
            repeat ($urandom_range(0, 3)) begin cmd_addr_i = 4'($urandom); tick; end
            do_cmd($sformatf("rnd%0d", i), wr, a, d, wt, rd, {4'h1, a}, d, wr ? 8'h00 : rd);
        end
        spur_en = 1'b0;

`ifdef SB_I2C_CTRL_TIMEOUT_EN
        // User command never acked.
        do_cmd("pre_tmo", 1'b0, 4'h7, 8'h00, 1, 8'h99, 8'h17, 8'h00, 8'h99);
        r0 = rsp_cnt; slave_wait = 9999;
        cmd_valid_i = 1'b1; cmd_write_i = 1'b0; cmd_addr_i = 4'h6; cmd_data_i = 8'h00;
        wait_ready;
        tick;
        acc = cyc; cmd_valid_i = 1'b0;
        hi = 0;
        while (sb_stb_o === 1'b1 && hi < 50) begin hi++; tick; end
        chk("tmo_strobe_cycles", hi, TMO);
        chk("tmo_rsp", {rsp_valid_o, rsp_timeout_o, rsp_data_o}, {1'b1, 1'b1, 8'h00});
        chk("tmo_latency", cyc - acc + 1, TMO + 1);
        tick;
        chk("tmo_pulse", {rsp_valid_o, rsp_timeout_o, cmd_ready_o}, 3'b001);
        chk("tmo_rsp_count", rsp_cnt, r0 + 1);
`endif

        // Reset in the middle of an unacked transfer.
        do_cmd("pre_rst", 1'b0, 4'h9, 8'h31, 0, 8'hE7, 8'h19, 8'h31, 8'hE7);
        r0 = rsp_cnt; slave_wait = 9999;
        cmd_valid_i = 1'b1; cmd_write_i = 1'b0; cmd_addr_i = 4'h5; cmd_data_i = 8'h00;
        wait_ready;
        tick;
        cmd_valid_i = 1'b0;
        repeat (HOLD) tick;
        chk("mid_xfer_strobe", sb_stb_o, 1);
        chk("mid_xfer_no_rsp", rsp_cnt, r0);
        apply_reset("rst_mid");
        obs_q.delete(); slave_wait = 1;
        rst_ni = 1'b1;
        check_init("reinit");
        chk("abandoned_no_rsp", rsp_cnt, r0);
        do_cmd("post_rst", 1'b1, 4'h1, 8'h5C, 2, 8'h00, 8'h11, 8'h5C, 8'h00);

`ifdef SB_I2C_CTRL_TIMEOUT_EN
        // Unacked init write restarts the sequence from CR1.
        slave_wait = 9999;
        apply_reset("rst_itmo");
        obs_q.delete(); r0 = rsp_cnt;
        rst_ni = 1'b1;
        n = 0;
        while (sb_stb_o !== 1'b1 && n < 50) begin tick; n++; end
        hi = 0;
        while (sb_stb_o === 1'b1 && hi < 50) begin hi++; tick; end
        chk("itmo_strobe_cycles", hi, TMO);
        n = 0;
        while (sb_stb_o !== 1'b1 && n < 50) begin tick; n++; end
        chk("itmo_restart", {sb_stb_o, sb_adr_o, sb_dat_o, init_done_o}, {1'b1, 8'h18, 8'h80, 1'b0});
        slave_wait = 1;
        check_init("itmo_init");
        chk("itmo_no_rsp", rsp_cnt, r0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
